// File: rtl/corner_nms_collector.sv
// rtl/corner_nms_collector.sv - 3x3 non-maximum suppression corner collector over the score map
//
// Scans one WIDTH x HEIGHT score frame in raster order per start pulse. It
// keeps pixels that are local maxima in a 3x3 window and above a threshold,
// and writes them as {0, y, x, score} records into a corner-list RAM.
//
// Ports:
//   clock, nReset        single clock, asynchronous active-low reset
//   start, thres         frame trigger pulse (ignored while busy) and score threshold
//   score_addr/rd/q      score memory read port; data returns one cycle after score_rd
//   corner_wr/addr/data  corner-list write port
//   corner_count         records written this frame (held until next start)
//   overflow             sticky: more kept candidates than list capacity
//   busy, done           scan in progress / one-cycle end-of-scan pulse

module corner_nms_collector #(
    parameter int WIDTH       = 180,
    parameter int HEIGHT      = 120,
    parameter int ADDR_W      = 15,
    parameter int MAX_CORNERS = 64,
    parameter int CW          = 6
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              start,
    input  logic [7:0]        thres,
    output logic [ADDR_W-1:0] score_addr,
    output logic              score_rd,
    input  logic [7:0]        score_q,
    output logic              corner_wr,
    output logic [CW-1:0]     corner_addr,
    output logic [23:0]       corner_data,
    output logic [CW:0]       corner_count,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]        X_LAST   = 8'(WIDTH - 1);
    localparam logic [6:0]        Y_LAST   = 7'(HEIGHT - 1);
    localparam logic [CW:0]       CNT_MAX  = (CW + 1)'(MAX_CORNERS);
    localparam logic [CW:0]       CNT_ONE  = (CW + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    // Scan control
    state_t            state_q, state_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              drain_q, drain_d;

    // Coordinates of the read issued last cycle; its data is on score_q now
    logic              pv_q, pv_d;
    logic [7:0]        px_q, px_d;
    logic [6:0]        py_q, py_d;

    // Window columns x-2 (col_a) and x-1 (col_b); index 0 = row y-2, 1 = y-1, 2 = y
    logic [2:0][7:0]   col_a_q, col_a_d;
    logic [2:0][7:0]   col_b_q, col_b_d;

    // Corner-list write port and frame results
    logic              wr_q, wr_d;
    logic [CW-1:0]     waddr_q, waddr_d;
    logic [23:0]       wdata_q, wdata_d;
    logic [CW:0]       cnt_q, cnt_d;
    logic [CW:0]       count_q, count_d;
    logic              ovf_q, ovf_d;

    // Line buffers holding rows y-1 (line1) and y-2 (line2)
    logic [7:0]        line1_q [0:WIDTH-1];
    logic [7:0]        line2_q [0:WIDTH-1];

    logic [2:0][7:0]   new_col;
    logic [7:0]        s_ctr;
    logic              evaluate;
    logic              kept;
    logic [7:0]        cx;
    logic [6:0]        cy;

    always_comb begin
        new_col[0] = line2_q[px_q];
        new_col[1] = line1_q[px_q];
        new_col[2] = score_q;
    end

    assign s_ctr = col_b_q[1];
    assign cx    = px_q - 8'd1;
    assign cy    = py_q - 7'd1;

    // Window centre is (x-1, y-1); rows/columns 0 and 1 of the arriving pixel
    // would put the centre on the border, so those are never evaluated.
    assign evaluate = pv_q && (px_q >= 8'd2) && (py_q >= 7'd2);

    // Strict against raster-preceding neighbours, non-strict against following
    // ones, so a flat plateau yields only its first pixel in raster order.
    assign kept = (s_ctr >  thres)
               && (s_ctr >  col_a_q[0]) && (s_ctr >  col_b_q[0]) && (s_ctr >  new_col[0])
               && (s_ctr >  col_a_q[1])
               && (s_ctr >= new_col[1])
               && (s_ctr >= col_a_q[2]) && (s_ctr >= col_b_q[2]) && (s_ctr >= new_col[2]);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        pv_d    = (state_q == ST_READ);
        px_d    = x_q;
        py_d    = y_q;
        col_a_d = col_a_q;
        col_b_d = col_b_q;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        count_d = cnt_q;
        ovf_d   = ovf_q;

        if (pv_q) begin
            col_a_d = col_b_q;
            col_b_d = new_col;
        end

        if (evaluate && kept) begin
            if (cnt_q < CNT_MAX) begin
                wr_d    = 1'b1;
                waddr_d = cnt_q[CW-1:0];
                wdata_d = {1'b0, cy, cx, s_ctr};
                cnt_d   = cnt_q + CNT_ONE;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    x_d     = 8'd0;
                    y_d     = 7'd0;
                    addr_d  = '0;
                    cnt_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_READ: begin
                if (x_q == X_LAST) begin
                    x_d = 8'd0;
                    if (y_q == Y_LAST) begin
                        state_d = ST_DRAIN;
                        y_d     = 7'd0;
                        addr_d  = '0;
                        drain_d = 1'b0;
                    end else begin
                        y_d    = y_q + 7'd1;
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else begin
                    x_d    = x_q + 8'd1;
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                // First cycle: last data return; second: last decision/write
                if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            drain_q <= 1'b0;
            pv_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            col_a_q <= '0;
            col_b_q <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            pv_q    <= pv_d;
            px_q    <= px_d;
            py_q    <= py_d;
            col_a_q <= col_a_d;
            col_b_q <= col_b_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Line buffers shift the arriving column down one row; old values are read
    // combinationally above before this write takes effect.
    always_ff @(posedge clock) begin
        if (pv_q) begin
            line1_q[px_q] <= score_q;
            line2_q[px_q] <= line1_q[px_q];
        end
    end

    assign score_rd     = (state_q == ST_READ);
    assign score_addr   = addr_q;
    assign corner_wr    = wr_q;
    assign corner_addr  = waddr_q;
    assign corner_data  = wdata_q;
    assign corner_count = count_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_corner_nms_collector.sv
// tb/tb_corner_nms_collector.sv - scoreboard bench for corner_nms_collector

module tb_corner_nms_collector;

    localparam int W = 180;
    localparam int H = 120;
    localparam int N = W * H;
    localparam int DONE_CYC = 21603;
    localparam int LAST_CYC = 21605;

    logic        clock = 1'b0;
    logic        nReset;
    logic        start;
    logic [7:0]  thres;
    logic [14:0] score_addr;
    logic        score_rd;
    logic [7:0]  score_q = 8'd0;
    logic        corner_wr;
    logic [5:0]  corner_addr;
    logic [23:0] corner_data;
    logic [6:0]  corner_count;
    logic        overflow;
    logic        busy;
    logic        done;

    corner_nms_collector dut (
        .clock        (clock),
        .nReset       (nReset),
        .start        (start),
        .thres        (thres),
        .score_addr   (score_addr),
        .score_rd     (score_rd),
        .score_q      (score_q),
        .corner_wr    (corner_wr),
        .corner_addr  (corner_addr),
        .corner_data  (corner_data),
        .corner_count (corner_count),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [0:N-1];

    always @(posedge clock) begin
        if (score_rd) score_q <= (int'(score_addr) < N) ? mem[score_addr] : 8'h00;
    end

    typedef struct packed {
        logic [5:0]  addr;
        logic [23:0] data;
    } rec_t;

    rec_t        exp_q[$];
    int          exp_count;
    logic        exp_ovf;
    logic [23:0] seen_data[$];
    int          wr_seen;
    int          done_cyc;
    int          done_pulses;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [7:0] px(input int x, input int y);
        return mem[y * W + x];
    endfunction

    task automatic clear_map();
        for (int i = 0; i < N; i++) mem[i] = 8'd0;
    endtask

    task automatic set_pix(input int x, input int y, input logic [7:0] v);
        mem[y * W + x] = v;
    endtask

    // Reference NMS straight from the keep rule, centres in raster order
    task automatic build_expected();
        logic [7:0] s;
        logic       k;
        exp_q.delete();
        exp_count = 0;
        exp_ovf = 1'b0;
        for (int cy = 1; cy < H - 1; cy++) begin
            for (int cx = 1; cx < W - 1; cx++) begin
                s = px(cx, cy);
                k = (s > thres)
                    && (s > px(cx-1, cy-1)) && (s > px(cx, cy-1)) && (s > px(cx+1, cy-1))
                    && (s > px(cx-1, cy))
                    && (s >= px(cx+1, cy))
                    && (s >= px(cx-1, cy+1)) && (s >= px(cx, cy+1)) && (s >= px(cx+1, cy+1));
                if (k) begin
                    if (exp_count < 64) begin
                        exp_q.push_back({6'(exp_count), 1'b0, 7'(cy), 8'(cx), s});
                        exp_count++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    // Runs one frame from a start pulse; optional stray start and async reset
    task automatic run_frame(input int stray_start_cyc, input int rst_cyc);
        rec_t e;
        int   busy_err;
        int   rd_err;
        logic rst_hit;
        busy_err = 0;
        rd_err = 0;
        rst_hit = 1'b0;
        wr_seen = 0;
        done_cyc = -1;
        done_pulses = 0;
        seen_data.delete();
        @(negedge clock);
        start = 1'b1;
        for (int cyc = 1; cyc <= LAST_CYC; cyc++) begin
            @(posedge clock);
            #1;
            start = (cyc == stray_start_cyc);
            if (cyc == rst_cyc) begin
                nReset = 1'b0;
                #1;
                n_checks++;
                if ({score_rd, score_addr, corner_wr, corner_addr, corner_data, corner_count,
                     overflow, busy, done} !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset_outputs: got rd=%b addr=%0d wr=%b caddr=%0d data=%h cnt=%0d ovf=%b busy=%b done=%b, required all 0",
                             score_rd, score_addr, corner_wr, corner_addr, corner_data,
                             corner_count, overflow, busy, done);
                end
                start = 1'b0;
                rst_hit = 1'b1;
                break;
            end
            @(negedge clock);
            if (busy !== (cyc <= DONE_CYC)) busy_err++;
            if (score_rd !== (cyc <= 21600)) rd_err++;
            if (cyc == 1) begin
                n_checks++;
                if (corner_count !== 7'd0 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_clears: got count=%0d ovf=%b, required 0 and 0",
                             corner_count, overflow);
                end
            end
            if (corner_wr === 1'b1) begin
                wr_seen++;
                seen_data.push_back(corner_data);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_write: got addr=%0d data=%h at cycle %0d, required no write",
                             corner_addr, corner_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (corner_addr !== e.addr || corner_data !== e.data) begin
                        n_fail++;
                        $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 corner_addr, corner_data, e.addr, e.data);
                    end
                end
            end
            if (done === 1'b1) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
                n_checks++;
                if (corner_count !== 7'(exp_count)) begin
                    n_fail++;
                    $display("FAIL count_at_done: got %0d, required %0d", corner_count, exp_count);
                end
            end
        end
        if (rst_hit) begin
            repeat (2) @(negedge clock);
            nReset = 1'b1;
            @(negedge clock);
            return;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_missing_writes: got %0d writes, required %0d more", wr_seen, exp_q.size());
        end
        n_checks++;
        if (done_cyc != DONE_CYC || done_pulses != 1) begin
            n_fail++;
            $display("FAIL done_timing: got cycle %0d pulses %0d, required cycle %0d pulses 1",
                     done_cyc, done_pulses, DONE_CYC);
        end
        n_checks++;
        if (busy_err != 0 || rd_err != 0) begin
            n_fail++;
            $display("FAIL busy_rd_window: got %0d busy and %0d score_rd bad cycles, required 0",
                     busy_err, rd_err);
        end
        n_checks++;
        if (corner_count !== 7'(exp_count) || overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL hold_after_done: got count=%0d ovf=%b, required count=%0d ovf=%b",
                     corner_count, overflow, exp_count, exp_ovf);
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        start = 1'b0;
        thres = 8'd0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({score_rd, score_addr, corner_wr, corner_addr, corner_data, corner_count,
             overflow, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rd=%b addr=%0d wr=%b data=%h cnt=%0d ovf=%b busy=%b done=%b, required all 0",
                     score_rd, score_addr, corner_wr, corner_data, corner_count, overflow, busy, done);
        end
        nReset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_overflow();
        clear_map();
        thres = 8'd10;
        for (int j = 0; j < 10; j++)
            for (int i = 0; i < 10; i++)
                set_pix(6 + 6 * i, 6 + 6 * j, 8'd99);
        build_expected();
        run_frame(0, 0);
        n_checks++;
        if (wr_seen != 64 || corner_count !== 7'd64 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got writes=%0d count=%0d ovf=%b, required 64 64 1",
                     wr_seen, corner_count, overflow);
        end
        n_checks++;
        if (seen_data.size() != 64 || seen_data[0] !== 24'h060663 || seen_data[63] !== 24'h2A1863) begin
            n_fail++;
            $display("FAIL overflow_order: got %0d records, first/last wrong, required 060663 .. 2A1863",
                     seen_data.size());
        end
    endtask

    task automatic test_blank_stray_start();
        clear_map();
        thres = 8'd0;
        build_expected();
        run_frame(5000, 0);
        n_checks++;
        if (wr_seen != 0 || corner_count !== 7'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_frame: got writes=%0d count=%0d ovf=%b, required 0 0 0",
                     wr_seen, corner_count, overflow);
        end
    endtask

    task automatic load_feature_map();
        clear_map();
        thres = 8'd20;
        set_pix(10, 20, 8'd50);
        set_pix(0, 5, 8'd90);
        set_pix(179, 60, 8'd90);
        set_pix(50, 50, 8'd20);
        set_pix(30, 30, 8'd40);
        set_pix(31, 30, 8'd40);
        set_pix(100, 80, 8'd40);
        set_pix(101, 81, 8'd41);
        build_expected();
    endtask

    task automatic test_reset_midscan();
        load_feature_map();
        run_frame(0, 8000);
        n_checks++;
        if (wr_seen != 2) begin
            n_fail++;
            $display("FAIL writes_before_reset: got %0d, required 2", wr_seen);
        end
    endtask

    task automatic test_features();
        load_feature_map();
        run_frame(0, 0);
        n_checks++;
        if (wr_seen != 3 || corner_count !== 7'd3 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL features_count: got writes=%0d count=%0d ovf=%b, required 3 3 0",
                     wr_seen, corner_count, overflow);
        end
        n_checks++;
        if (seen_data.size() != 3 || seen_data[0] !== 24'h140A32 || seen_data[1] !== 24'h1E1E28
            || seen_data[2] !== 24'h516529) begin
            n_fail++;
            $display("FAIL features_data: got %0d records (last data %h), required 140A32 1E1E28 516529",
                     seen_data.size(), corner_data);
        end
    endtask

    initial begin
        nReset = 1'b0;
        start = 1'b0;
        thres = 8'd0;
        test_reset();
        test_overflow();
        test_blank_stray_start();
        test_reset_midscan();
        test_features();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/corner_nms_collector.md
Name: corner_nms_collector

Overview:
Consumes the per-pixel corner score map written by the score stage into ScoreMem, one 180x120 frame per start pulse. Scans the map in raster order and applies 3x3 non-maximum suppression plus a threshold. Writes surviving corners as (y, x, score) records into a corner-list RAM that the Amazon2 host reads. Sits directly downstream of the score memory, on Sys_clk, and is triggered by the frame-end interrupt.

Parameters:
WIDTH, 180, pixels per row
HEIGHT, 120, rows per frame
ADDR_W, 15, score memory address width
MAX_CORNERS, 64, corner-list capacity in records
CW, 6, corner-list address width (log2 MAX_CORNERS)

Ports:
clock  in  1  system clock (Sys_clk domain); single clock for the whole block
nReset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, frame scores complete; ignored while busy=1
thres  in  8  minimum score; a corner needs score > thres
score_addr  out  ADDR_W  score memory read address, y*WIDTH+x
score_rd  out  1  score memory read enable
score_q  in  8  score memory read data, valid one cycle after score_rd
corner_wr  out  1  corner-list write strobe
corner_addr  out  CW  corner-list write address
corner_data  out  24  {1'b0, y[6:0], x[7:0], score[7:0]}
corner_count  out  CW+1  records written this frame
overflow  out  1  more than MAX_CORNERS candidates this frame
busy  out  1  scan in progress
done  out  1  one-cycle pulse, scan finished, count stable

Behaviour:
- Reset (async, any time including mid-scan): state IDLE; score_rd=0, score_addr=0, corner_wr=0, corner_addr=0, corner_data=0, corner_count=0, overflow=0, busy=0, done=0. Line buffers need no reset.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 -> READ, clear corner_count and overflow, set x=0, y=0.
- READ: score_rd=1, score_addr=y*WIDTH+x, one address per cycle. x wraps at WIDTH-1 to 0 with y+1. After the read of (WIDTH-1, HEIGHT-1) -> DRAIN.
- DRAIN: 2 cycles, for the last data return and the last decision. Then -> DONE.
- DONE: done=1 for exactly 1 cycle -> IDLE.
- busy=1 in READ, DRAIN and DONE.
- Counter arithmetic: keep x/y counters and a running address incrementer; no multiplier.
- Pipeline: read issued at cycle t; score_q captured at t+1 into a 3x3 window and two WIDTH x 8 line buffers (rows y-1, y-2). Decision and corner_wr occur at t+2.
- Window: when pixel (x,y) arrives, the window centre is C=(x-1, y-1). Evaluate only if x>=2 and y>=2, so border pixels are never emitted. Window columns left over from the previous row are don't-care because of this guard.
- Keep rule, with S = score at C:
  - S > thres, and
  - S > each of the 4 raster-preceding neighbours (y-2 row all three, plus (x-2, y-1)), and
  - S >= each of the 4 raster-following neighbours.
  - The strict/non-strict split means a plateau emits exactly its first pixel in raster order.
- Emit, when kept and corner_count < MAX_CORNERS:
  - corner_wr=1, corner_addr=corner_count[CW-1:0], corner_data={0, Cy, Cx, S}.
  - corner_count increments the next cycle.
- Kept but corner_count == MAX_CORNERS: no write, overflow<=1 (sticky until the next start), corner_count saturates.
- Cycle budget: start sampled at cycle 0; reads at cycles 1..21600; last corner_wr possible at 21602; done at 21603; busy low at 21604. Back-to-back start accepted in IDLE at 21604.
- start during busy: ignored, no restart, no effect on the count.
- corner_count, corner_data and overflow hold their values after done until the next start.

Test Plan:
- All scores 0, thres=0, start -> no corner_wr, corner_count=0, overflow=0, done pulse exactly at cycle 21603, busy high cycles 1..21603.
- Single peak: score 50 at (10,20), thres=20, all else 0 -> one write, addr 0, data 0x140A32, corner_count=1.
- Border and threshold cases: score 90 at (0,5) and (179,60); score 20 at (50,50) with thres=20 -> no writes, corner_count=0.
- Plateau: score 40 at (30,30) and (31,30), thres=10 -> exactly one record, data 0x1E1E28. Ridge: 40 at (30,30), 41 at (31,31) -> only (31,31) emitted.
- Overflow: 100 isolated peaks of score 99 on a 6-pixel grid -> exactly 64 writes at addrs 0..63 in raster order, corner_count=64, overflow=1. Next start with a blank map clears both.
- Robustness: start pulsed at cycle 5000 mid-scan -> ignored, done still at 21603. nReset low at cycle 8000 -> all outputs 0 immediately, state IDLE. A new start afterwards completes a full frame normally.
